// File: rtl/stopwatch_pkg.sv
// Shared types and carry-chain helper for the lap stopwatch.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package stopwatch_pkg;

    // The fields are wide enough for any sensible HOURS_WRAP / MS_PER_SEC.
    // The top narrows them to its own HW / MSW widths at the ports.
    localparam int SW_HOURS_W = 8;
    localparam int SW_MSECS_W = 16;

    typedef enum logic [1:0] {
        READY  = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } sw_state_t;

    typedef struct packed {
        logic [SW_HOURS_W-1:0] hours;
        logic [5:0]            mins;
        logic [5:0]            secs;
        logic [SW_MSECS_W-1:0] msecs;
    } sw_time_t;

    typedef struct packed {
        sw_time_t t;
        logic     wrap;
    } sw_inc_t;

    // One ms tick with the full carry chain resolved in a single step.
    // hour_max / ms_max are the last legal values (HOURS_WRAP-1, MS_PER_SEC-1).
    function automatic sw_inc_t inc_time(input sw_time_t              cur,
                                         input logic [SW_HOURS_W-1:0] hour_max,
                                         input logic [SW_MSECS_W-1:0] ms_max);
        sw_inc_t r;
        r.t    = cur;
        r.wrap = 1'b0;
        if (cur.msecs != ms_max) begin
            r.t.msecs = cur.msecs + 1'b1;
        end else begin
            r.t.msecs = '0;
            if (cur.secs != 6'd59) begin
                r.t.secs = cur.secs + 1'b1;
            end else begin
                r.t.secs = '0;
                if (cur.mins != 6'd59) begin
                    r.t.mins = cur.mins + 1'b1;
                end else begin
                    r.t.mins = '0;
                    if (cur.hours != hour_max) begin
                        r.t.hours = cur.hours + 1'b1;
                    end else begin
                        r.t.hours = '0;
                        r.wrap    = 1'b1;
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lap_fifo.sv
// Synchronous show-ahead FIFO holding captured lap times.
// Latency: push visible at head the cycle after the push edge; pop advances head in one edge.
// Backpressure: push while full is dropped unless a pop happens the same edge; pop while empty ignored.
//
// Ports: Clock_1MSec / Reset (sync, active-high); clear empties the FIFO;
//        push/wdat write, pop removes head; head/valid show-ahead output;
//        count = entries held, full = count == DEPTH.
module lap_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             Clock_1MSec,
    input  logic             Reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign valid   = (count != '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && valid;
    // When full, a same-edge pop frees the slot the push writes into
    // (wr_ptr == rd_ptr), so the oldest entry is replaced in order.
    assign do_push = push && (!full || do_pop);
    assign head    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge Clock_1MSec) begin
        if (do_push) begin
            mem[wr_ptr] <= wdat;
        end
    end

    always_ff @(posedge Clock_1MSec) begin
        if (Reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lap_stopwatch.sv
// HH:MM:SS.mmm stopwatch on the 1 ms clock with pause/resume and lap capture FIFO.
// Latency: time advances one tick per RUN cycle; laps visible at Lap_* the cycle after capture.
// Backpressure: laps captured while the FIFO is full (and not popped) are dropped and flag Lap_Overflow.
//
// Ports: Clock_1MSec / Reset (sync, active-high); Start_S, Stop_S, Reset_S, Lap_S commands;
//        Control=1 freezes the block; Lap_Rd pops the lap FIFO head;
//        Hours_S/Mins_S/Secs_S/MSecs_S running time, Running, Wrap pulse;
//        Lap_* FIFO head, Lap_Valid, Lap_Count, sticky Lap_Overflow.
module lap_stopwatch
    import stopwatch_pkg::*;
#(
    parameter  int HOURS_WRAP = 12,
    parameter  int MS_PER_SEC = 1000,
    parameter  int LAP_DEPTH  = 8,
    localparam int HW         = $clog2(HOURS_WRAP),
    localparam int MSW        = $clog2(MS_PER_SEC),
    localparam int CW         = $clog2(LAP_DEPTH + 1)
) (
    input  logic           Clock_1MSec,
    input  logic           Reset,
    input  logic           Start_S,
    input  logic           Stop_S,
    input  logic           Reset_S,
    input  logic           Lap_S,
    input  logic           Control,
    input  logic           Lap_Rd,
    output logic [HW-1:0]  Hours_S,
    output logic [5:0]     Mins_S,
    output logic [5:0]     Secs_S,
    output logic [MSW-1:0] MSecs_S,
    output logic           Running,
    output logic           Wrap,
    output logic [HW-1:0]  Lap_Hours,
    output logic [5:0]     Lap_Mins,
    output logic [5:0]     Lap_Secs,
    output logic [MSW-1:0] Lap_MSecs,
    output logic           Lap_Valid,
    output logic [CW-1:0]  Lap_Count,
    output logic           Lap_Overflow
);

    localparam int LW = HW + 12 + MSW;
    localparam logic [SW_HOURS_W-1:0] H_MAX  = SW_HOURS_W'(HOURS_WRAP - 1);
    localparam logic [SW_MSECS_W-1:0] MS_MAX = SW_MSECS_W'(MS_PER_SEC - 1);

    sw_state_t     state;
    sw_time_t      time_q;
    sw_inc_t       inc_r;
    logic          running_q;
    logic          wrap_q;
    logic          ovf_q;

    logic          cmd_en;
    logic          clear_req;
    logic          lap_req;
    logic          pop_req;
    logic          lap_drop;
    logic          fifo_full;
    logic [LW-1:0] lap_wdat;
    logic [LW-1:0] lap_head;

    assign inc_r = inc_time(time_q, H_MAX, MS_MAX);

    // Control=1 blocks every command, including FIFO pops.
    assign cmd_en    = !Control;
    assign clear_req = cmd_en && (state == PAUSED) && Reset_S;
    // A lap captures the time shown before this edge's increment, even if
    // Stop_S arrives on the same cycle.
    assign lap_req   = cmd_en && (state == RUN) && Lap_S;
    assign pop_req   = cmd_en && !clear_req && Lap_Rd;
    assign lap_drop  = lap_req && fifo_full && !(pop_req && Lap_Valid);

    assign lap_wdat = {time_q.hours[HW-1:0], time_q.mins, time_q.secs, time_q.msecs[MSW-1:0]};

    lap_fifo #(
        .WIDTH (LW),
        .DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .Clock_1MSec (Clock_1MSec),
        .Reset       (Reset),
        .clear       (clear_req),
        .push        (lap_req),
        .wdat        (lap_wdat),
        .pop         (pop_req),
        .head        (lap_head),
        .valid       (Lap_Valid),
        .full        (fifo_full),
        .count       (Lap_Count)
    );

    always_ff @(posedge Clock_1MSec) begin
        if (Reset) begin
            state     <= READY;
            time_q    <= '0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (cmd_en) begin
                case (state)
                    READY: begin
                        // Higher-priority requests mask a start even though
                        // they have no effect of their own here.
                        if (Start_S && !Reset_S && !Stop_S) begin
                            state     <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (Stop_S) begin
                            state     <= PAUSED;
                            running_q <= 1'b0;
                        end else begin
                            time_q <= inc_r.t;
                            wrap_q <= inc_r.wrap;
                        end
                        if (lap_drop) ovf_q <= 1'b1;
                    end
                    PAUSED: begin
                        if (Reset_S) begin
                            state  <= READY;
                            time_q <= '0;
                            ovf_q  <= 1'b0;
                        end else if (!Stop_S && Start_S) begin
                            state     <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                    default: begin
                        state     <= READY;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Hours_S      = time_q.hours[HW-1:0];
    assign Mins_S       = time_q.mins;
    assign Secs_S       = time_q.secs;
    assign MSecs_S      = time_q.msecs[MSW-1:0];
    assign Running      = running_q;
    assign Wrap         = wrap_q;
    assign Lap_Overflow = ovf_q;

    assign Lap_MSecs = lap_head[MSW-1:0];
    assign Lap_Secs  = lap_head[MSW+5:MSW];
    assign Lap_Mins  = lap_head[MSW+11:MSW+6];
    assign Lap_Hours = lap_head[LW-1:MSW+12];

endmodule

// File: tb/tb_lap_stopwatch.sv
module tb_lap_stopwatch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: default parameters (12 h wrap, 1000 ms per second, 8 laps)
    logic       a_reset, a_start, a_stop, a_reset_s, a_lap, a_ctrl, a_rd;
    logic [3:0] a_hours, a_lhours;
    logic [5:0] a_mins, a_secs, a_lmins, a_lsecs;
    logic [9:0] a_msecs, a_lmsecs;
    logic       a_running, a_wrap, a_lvalid, a_ovf;
    logic [3:0] a_lcount;

    // Instance B: tiny wrap period so a full wrap fits in a short run
    logic       b_reset, b_start;
    logic       b_zero;
    logic [0:0] b_hours, b_lhours;
    logic [5:0] b_mins, b_secs, b_lmins, b_lsecs;
    logic [0:0] b_msecs, b_lmsecs;
    logic       b_running, b_wrap, b_lvalid, b_ovf;
    logic [3:0] b_lcount;

    lap_stopwatch u_dut_a (
        .Clock_1MSec (clk),       .Reset       (a_reset),
        .Start_S     (a_start),   .Stop_S      (a_stop),
        .Reset_S     (a_reset_s), .Lap_S       (a_lap),
        .Control     (a_ctrl),    .Lap_Rd      (a_rd),
        .Hours_S     (a_hours),   .Mins_S      (a_mins),
        .Secs_S      (a_secs),    .MSecs_S     (a_msecs),
        .Running     (a_running), .Wrap        (a_wrap),
        .Lap_Hours   (a_lhours),  .Lap_Mins    (a_lmins),
        .Lap_Secs    (a_lsecs),   .Lap_MSecs   (a_lmsecs),
        .Lap_Valid   (a_lvalid),  .Lap_Count   (a_lcount),
        .Lap_Overflow(a_ovf)
    );

    lap_stopwatch #(.HOURS_WRAP(2), .MS_PER_SEC(2), .LAP_DEPTH(8)) u_dut_b (
        .Clock_1MSec (clk),       .Reset       (b_reset),
        .Start_S     (b_start),   .Stop_S      (b_zero),
        .Reset_S     (b_zero),    .Lap_S       (b_zero),
        .Control     (b_zero),    .Lap_Rd      (b_zero),
        .Hours_S     (b_hours),   .Mins_S      (b_mins),
        .Secs_S      (b_secs),    .MSecs_S     (b_msecs),
        .Running     (b_running), .Wrap        (b_wrap),
        .Lap_Hours   (b_lhours),  .Lap_Mins    (b_lmins),
        .Lap_Secs    (b_lsecs),   .Lap_MSecs   (b_lmsecs),
        .Lap_Valid   (b_lvalid),  .Lap_Count   (b_lcount),
        .Lap_Overflow(b_ovf)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pa(input int h, input int m, input int s, input int ms);
        return {6'd0, 4'(h), 6'(m), 6'(s), 10'(ms)};
    endfunction

    function automatic logic [31:0] pb(input int h, input int m, input int s, input int ms);
        return {18'd0, 1'(h), 6'(m), 6'(s), 1'(ms)};
    endfunction

    function automatic logic [31:0] a_time();
        return {6'd0, a_hours, a_mins, a_secs, a_msecs};
    endfunction

    function automatic logic [31:0] a_head();
        return {6'd0, a_lhours, a_lmins, a_lsecs, a_lmsecs};
    endfunction

    function automatic logic [31:0] b_time();
        return {18'd0, b_hours, b_mins, b_secs, b_msecs};
    endfunction

    task automatic a_do_reset();
        a_reset = 1'b1;
        step(1);
        a_reset = 1'b0;
    endtask

    initial begin
        int exp_order [8] = '{1, 2, 3, 4, 5, 6, 7, 9};

        a_reset = 1'b1; a_start = 1'b0; a_stop = 1'b0; a_reset_s = 1'b0;
        a_lap = 1'b0; a_ctrl = 1'b0; a_rd = 1'b0;
        b_reset = 1'b1; b_start = 1'b0; b_zero = 1'b0;

        // Reset values
        step(1);
        chk("rst_time",    a_time(), pa(0, 0, 0, 0));
        chk("rst_running", 32'(a_running), 32'd0);
        chk("rst_wrap",    32'(a_wrap), 32'd0);
        chk("rst_count",   32'(a_lcount), 32'd0);
        chk("rst_valid",   32'(a_lvalid), 32'd0);
        chk("rst_ovf",     32'(a_ovf), 32'd0);
        chk("rst_head",    a_head(), pa(0, 0, 0, 0));
        chk("rst_b_time",  b_time(), pb(0, 0, 0, 0));
        a_reset = 1'b0;
        b_reset = 1'b0;

        // 1. Start, 1500 ticks, stop -> 00:00:01.500 and held
        a_start = 1'b1;
        step(1);
        a_start = 1'b0;
        chk("t1_start_time", a_time(), pa(0, 0, 0, 0));
        chk("t1_running",    32'(a_running), 32'd1);
        step(1500);
        a_stop = 1'b1;
        step(1);
        a_stop = 1'b0;
        chk("t1_stop_time",    a_time(), pa(0, 0, 1, 500));
        chk("t1_stop_running", 32'(a_running), 32'd0);
        step(100);
        chk("t1_held_time", a_time(), pa(0, 0, 1, 500));

        // 3. Laps at ms 10, 20, 30; pop the head
        a_do_reset();
        a_start = 1'b1;
        step(1);
        a_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(k == 0 ? 10 : 9);
            a_lap = 1'b1;
            step(1);
            a_lap = 1'b0;
        end
        chk("t3_count", 32'(a_lcount), 32'd3);
        chk("t3_valid", 32'(a_lvalid), 32'd1);
        chk("t3_head0", a_head(), pa(0, 0, 0, 10));
        a_rd = 1'b1;
        step(1);
        a_rd = 1'b0;
        chk("t3_head1",  a_head(), pa(0, 0, 0, 20));
        chk("t3_count1", 32'(a_lcount), 32'd2);

        // 4. Nine laps into an 8-deep FIFO, then lap+pop while full
        a_do_reset();
        a_start = 1'b1;
        step(1);
        a_start = 1'b0;
        a_lap = 1'b1;
        step(9);
        a_lap = 1'b0;
        chk("t4_count_full", 32'(a_lcount), 32'd8);
        chk("t4_ovf",        32'(a_ovf), 32'd1);
        chk("t4_head0",      a_head(), pa(0, 0, 0, 0));
        chk("t4_time",       a_time(), pa(0, 0, 0, 9));
        a_lap = 1'b1;
        a_rd  = 1'b1;
        step(1);
        a_lap = 1'b0;
        chk("t4_count_pushpop", 32'(a_lcount), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t4_order%0d", i), a_head(), pa(0, 0, 0, exp_order[i]));
            step(1);
        end
        a_rd = 1'b0;
        chk("t4_count_empty", 32'(a_lcount), 32'd0);
        chk("t4_valid_empty", 32'(a_lvalid), 32'd0);
        chk("t4_head_empty",  a_head(), pa(0, 0, 0, 0));

        // 5. Reset_S ignored in RUN; pause/resume; Reset_S clears in PAUSED
        a_do_reset();
        a_start = 1'b1;
        step(1);
        a_start = 1'b0;
        a_lap = 1'b1;
        step(9);
        a_lap = 1'b0;
        a_reset_s = 1'b1;
        step(1);
        a_reset_s = 1'b0;
        chk("t5_rs_run_time",    a_time(), pa(0, 0, 0, 10));
        chk("t5_rs_run_running", 32'(a_running), 32'd1);
        chk("t5_rs_run_count",   32'(a_lcount), 32'd8);
        a_stop = 1'b1;
        step(1);
        a_stop = 1'b0;
        chk("t5_paused_time", a_time(), pa(0, 0, 0, 10));
        a_start = 1'b1;
        step(1);
        a_start = 1'b0;
        chk("t5_resume_running", 32'(a_running), 32'd1);
        chk("t5_resume_time",    a_time(), pa(0, 0, 0, 10));
        step(3);
        chk("t5_resumed_time", a_time(), pa(0, 0, 0, 13));
        a_stop = 1'b1;
        step(1);
        a_stop = 1'b0;
        a_reset_s = 1'b1;
        step(1);
        a_reset_s = 1'b0;
        chk("t5_clr_time",    a_time(), pa(0, 0, 0, 0));
        chk("t5_clr_running", 32'(a_running), 32'd0);
        chk("t5_clr_count",   32'(a_lcount), 32'd0);
        chk("t5_clr_valid",   32'(a_lvalid), 32'd0);
        chk("t5_clr_ovf",     32'(a_ovf), 32'd0);
        a_start = 1'b1;
        step(1);
        a_start = 1'b0;
        step(2);
        chk("t5_restart_time", a_time(), pa(0, 0, 0, 2));

        // 6. Control=1 freezes everything; then Reset wins over all inputs
        a_ctrl = 1'b1;
        a_rd   = 1'b1;
        for (int i = 0; i < 50; i++) begin
            a_start = i[0];
            a_stop  = i[1];
            a_lap   = i[2];
            step(1);
        end
        a_ctrl = 1'b0; a_rd = 1'b0; a_start = 1'b0; a_stop = 1'b0; a_lap = 1'b0;
        chk("t6_ctrl_time",    a_time(), pa(0, 0, 0, 2));
        chk("t6_ctrl_running", 32'(a_running), 32'd1);
        chk("t6_ctrl_count",   32'(a_lcount), 32'd0);
        step(1);
        chk("t6_after_time", a_time(), pa(0, 0, 0, 3));
        a_lap = 1'b1;
        step(1);
        a_lap = 1'b0;
        chk("t6_lap_count", 32'(a_lcount), 32'd1);
        chk("t6_lap_head",  a_head(), pa(0, 0, 0, 3));
        a_reset = 1'b1; a_start = 1'b1; a_lap = 1'b1; a_rd = 1'b1; a_reset_s = 1'b1;
        step(1);
        a_reset = 1'b0; a_start = 1'b0; a_lap = 1'b0; a_rd = 1'b0; a_reset_s = 1'b0;
        chk("t6_rst_time",    a_time(), pa(0, 0, 0, 0));
        chk("t6_rst_running", 32'(a_running), 32'd0);
        chk("t6_rst_count",   32'(a_lcount), 32'd0);
        chk("t6_rst_valid",   32'(a_lvalid), 32'd0);
        chk("t6_rst_head",    a_head(), pa(0, 0, 0, 0));
        chk("t6_rst_wrap",    32'(a_wrap), 32'd0);

        // 2. Full wrap on instance B: 2 h * 3600 s * 2 ticks = 14400 ticks per period
        b_start = 1'b1;
        step(1);
        b_start = 1'b0;
        step(14398);
        chk("t2_pre_time", b_time(), pb(1, 59, 59, 0));
        chk("t2_pre_wrap", 32'(b_wrap), 32'd0);
        step(1);
        chk("t2_last_time", b_time(), pb(1, 59, 59, 1));
        chk("t2_last_wrap", 32'(b_wrap), 32'd0);
        step(1);
        chk("t2_wrap_time", b_time(), pb(0, 0, 0, 0));
        chk("t2_wrap_hi",   32'(b_wrap), 32'd1);
        step(1);
        chk("t2_post_time", b_time(), pb(0, 0, 0, 1));
        chk("t2_wrap_lo",   32'(b_wrap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
